// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcodes, bank addresses, ALU codes,
// state encoding and the control-word layout driven into memory_system.
package cu_pkg;

   localparam logic [4:0] OP_NOP         = 5'b00000;
   localparam logic [4:0] OP_MOV_ACC_A   = 5'b00001;
   localparam logic [4:0] OP_MOV_A_ACC   = 5'b00010;
   localparam logic [4:0] OP_LD_ACC_IMM  = 5'b00011;
   localparam logic [4:0] OP_LD_ACC_DPTR = 5'b00100;
   localparam logic [4:0] OP_ST_ACC_DPTR = 5'b00101;
   localparam logic [4:0] OP_ADD_A       = 5'b00110;
   localparam logic [4:0] OP_SUB_A       = 5'b00111;
   localparam logic [4:0] OP_AND_A       = 5'b01000;
   localparam logic [4:0] OP_SHL_ACC     = 5'b01001;
   localparam logic [4:0] OP_JZ          = 5'b01010;
   localparam logic [4:0] OP_JMP         = 5'b01011;
   localparam logic [4:0] OP_HALT        = 5'b11111;

   localparam logic [2:0] REG_PC   = 3'b000;
   localparam logic [2:0] REG_DPTR = 3'b001;
   localparam logic [2:0] REG_A    = 3'b010;
   localparam logic [2:0] REG_ACC  = 3'b011;
   localparam logic [2:0] REG_TEMP = 3'b100;
   localparam logic [2:0] REG_MDR  = 3'b111;

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b001;
   localparam logic [2:0] ALU_SUB    = 3'b010;
   localparam logic [2:0] ALU_AND    = 3'b011;
   localparam logic [2:0] ALU_OR     = 3'b100;
   localparam logic [2:0] ALU_XOR    = 3'b101;
   localparam logic [2:0] ALU_INC_B  = 3'b110;
   localparam logic [2:0] ALU_SHL_B  = 3'b111;

   typedef enum logic [4:0] {
      ST_RST    = 5'd0,  ST_F0     = 5'd1,  ST_F1     = 5'd2,  ST_F2     = 5'd3,
      ST_DEC    = 5'd4,  ST_E1_AA  = 5'd5,  ST_E1_AAC = 5'd6,  ST_I0     = 5'd7,
      ST_I1     = 5'd8,  ST_I2     = 5'd9,  ST_I3     = 5'd10, ST_M0     = 5'd11,
      ST_M1     = 5'd12, ST_S1     = 5'd13, ST_S2     = 5'd14, ST_EA_ADD = 5'd15,
      ST_EA_SUB = 5'd16, ST_EA_AND = 5'd17, ST_EA_SHL = 5'd18, ST_J2     = 5'd19,
      ST_HALT   = 5'd20
   } state_t;

   typedef struct packed {
      logic       ir_sclr;
      logic       mar_sclr;
      logic       enaf;
      logic [2:0] selop;
      logic [1:0] shamt;
      logic       bank_wr_en;
      logic [2:0] busB_addr;
      logic [2:0] busC_addr;
      logic       ir_en;
      logic       mar_en;
      logic       mdr_en;
      logic       wr_rdn;
      logic       mdr_alu_n;
      logic       halted;
   } ctrl_t;

   function automatic logic opcode_defined(input logic [4:0] op);
      logic ok;
      case (op)
         OP_NOP, OP_MOV_ACC_A, OP_MOV_A_ACC, OP_LD_ACC_IMM, OP_LD_ACC_DPTR,
         OP_ST_ACC_DPTR, OP_ADD_A, OP_SUB_A, OP_AND_A, OP_SHL_ACC, OP_JZ,
         OP_JMP, OP_HALT: ok = 1'b1;
         default:         ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/cu_ctrl_rom.sv
// Combinational state -> control-word decode; every field not set for a state
// stays 0.
module cu_ctrl_rom
   import cu_pkg::*;
#(
   parameter logic [1:0] SHL_AMT = 2'd1
) (
   input  state_t state,
   output ctrl_t  ctrl
);

   // Control word for each state
   always_comb begin
      ctrl = '0;
      case (state)
         ST_RST: begin
            ctrl.ir_sclr  = 1'b1;
            ctrl.mar_sclr = 1'b1;
         end
         ST_F0, ST_I0: begin
            ctrl.busB_addr = REG_PC;
            ctrl.selop     = ALU_PASS_B;
            ctrl.mar_en    = 1'b1;
         end
         ST_M0: begin
            ctrl.busB_addr = REG_DPTR;
            ctrl.selop     = ALU_PASS_B;
            ctrl.mar_en    = 1'b1;
         end
         ST_F1, ST_I1, ST_M1: begin
            ctrl.mdr_alu_n = 1'b1;
            ctrl.mdr_en    = 1'b1;
         end
         ST_F2, ST_I3: begin
            ctrl.ir_en      = (state == ST_F2);
            ctrl.busB_addr  = REG_PC;
            ctrl.selop      = ALU_INC_B;
            ctrl.bank_wr_en = 1'b1;
            ctrl.busC_addr  = REG_PC;
         end
         ST_E1_AA: begin
            ctrl.busB_addr  = REG_A;
            ctrl.bank_wr_en = 1'b1;
            ctrl.busC_addr  = REG_ACC;
         end
         ST_E1_AAC: begin
            ctrl.busB_addr  = REG_ACC;
            ctrl.bank_wr_en = 1'b1;
            ctrl.busC_addr  = REG_A;
         end
         ST_I2, ST_J2: begin
            ctrl.busB_addr  = REG_MDR;
            ctrl.bank_wr_en = 1'b1;
            ctrl.busC_addr  = (state == ST_J2) ? REG_PC : REG_ACC;
         end
         ST_S1: begin
            ctrl.busB_addr = REG_ACC;
            ctrl.mdr_en    = 1'b1;
         end
         ST_S2:   ctrl.wr_rdn = 1'b1;
         ST_EA_ADD, ST_EA_SUB, ST_EA_AND, ST_EA_SHL: begin
            ctrl.enaf       = 1'b1;
            ctrl.bank_wr_en = 1'b1;
            ctrl.busC_addr  = REG_ACC;
            ctrl.busB_addr  = REG_A;
            case (state)
               ST_EA_ADD: ctrl.selop = ALU_ADD;
               ST_EA_SUB: ctrl.selop = ALU_SUB;
               ST_EA_AND: ctrl.selop = ALU_AND;
               default: begin
                  ctrl.selop     = ALU_SHL_B;
                  ctrl.busB_addr = REG_ACC;
                  ctrl.shamt     = SHL_AMT;
               end
            endcase
         end
         ST_HALT: ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer for memory_system: fetch, decode and execute one
// instruction at a time.
module control_unit
   import cu_pkg::*;
#(
   parameter int         OPC_WIDTH = 5,
   parameter logic [1:0] SHL_AMT   = 2'd1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OPC_WIDTH-1:0] instruction,
   input  logic                 C,
   input  logic                 N,
   input  logic                 P,
   input  logic                 Z,
   output logic                 ir_sclr,
   output logic                 mar_sclr,
   output logic                 enaf,
   output logic [2:0]           selop,
   output logic [1:0]           shamt,
   output logic                 bank_wr_en,
   output logic [2:0]           busB_addr,
   output logic [2:0]           busC_addr,
   output logic                 ir_en,
   output logic                 mar_en,
   output logic                 mdr_en,
   output logic                 wr_rdn,
   output logic                 mdr_alu_n,
   output logic                 halted,
   output logic                 illegal,
   output logic [4:0]           state_m
);

   state_t state_r;
   state_t next_state_s;
   ctrl_t  ctrl_s;
   logic   unused_flags_s;

   // Only Z steers the sequence; the other flags are consumed by the datapath.
   assign unused_flags_s = ^{C, N, P};

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RST;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; IR is stable through execute, so later states re-read it
   always_comb begin
      next_state_s = ST_RST;
      case (state_r)
         ST_RST: next_state_s = ST_F0;
         ST_F0:  next_state_s = ST_F1;
         ST_F1:  next_state_s = ST_F2;
         ST_F2:  next_state_s = ST_DEC;
         ST_DEC: begin
            case (instruction)
               OP_MOV_ACC_A:   next_state_s = ST_E1_AA;
               OP_MOV_A_ACC:   next_state_s = ST_E1_AAC;
               OP_LD_ACC_IMM:  next_state_s = ST_I0;
               OP_LD_ACC_DPTR: next_state_s = ST_M0;
               OP_ST_ACC_DPTR: next_state_s = ST_M0;
               OP_ADD_A:       next_state_s = ST_EA_ADD;
               OP_SUB_A:       next_state_s = ST_EA_SUB;
               OP_AND_A:       next_state_s = ST_EA_AND;
               OP_SHL_ACC:     next_state_s = ST_EA_SHL;
               OP_JMP:         next_state_s = ST_I0;
               OP_JZ:          next_state_s = Z ? ST_I0 : ST_I3;
               OP_HALT:        next_state_s = ST_HALT;
               default:        next_state_s = ST_F0;
            endcase
         end
         ST_I0:  next_state_s = ST_I1;
         ST_I1:  next_state_s = (instruction == OP_LD_ACC_IMM) ? ST_I2 : ST_J2;
         ST_I2:  next_state_s = (instruction == OP_LD_ACC_IMM) ? ST_I3 : ST_F0;
         ST_M0:  next_state_s = (instruction == OP_ST_ACC_DPTR) ? ST_S1 : ST_M1;
         ST_M1:  next_state_s = ST_I2;
         ST_S1:  next_state_s = ST_S2;
         ST_HALT: next_state_s = ST_HALT;
         ST_I3, ST_S2, ST_E1_AA, ST_E1_AAC, ST_EA_ADD, ST_EA_SUB, ST_EA_AND,
         ST_EA_SHL, ST_J2: next_state_s = ST_F0;
         default: next_state_s = ST_RST;
      endcase
   end

   cu_ctrl_rom #(.SHL_AMT(SHL_AMT)) u_rom (
      .state (state_r),
      .ctrl  (ctrl_s)
   );

   assign ir_sclr    = ctrl_s.ir_sclr;
   assign mar_sclr   = ctrl_s.mar_sclr;
   assign enaf       = ctrl_s.enaf;
   assign selop      = ctrl_s.selop;
   assign shamt      = ctrl_s.shamt;
   assign bank_wr_en = ctrl_s.bank_wr_en;
   assign busB_addr  = ctrl_s.busB_addr;
   assign busC_addr  = ctrl_s.busC_addr;
   assign ir_en      = ctrl_s.ir_en;
   assign mar_en     = ctrl_s.mar_en;
   assign mdr_en     = ctrl_s.mdr_en;
   assign wr_rdn     = ctrl_s.wr_rdn;
   assign mdr_alu_n  = ctrl_s.mdr_alu_n;
   assign halted     = ctrl_s.halted;
   assign illegal    = (state_r == ST_DEC) && !opcode_defined(instruction);
   assign state_m    = state_r;

endmodule
